// File: rtl/gf32_serial_mult.sv
// rtl/gf32_serial_mult.sv - bit-serial GF(2^32) multiplier, MSB-first shift-and-add with reduction
// Optional macro GF32_DIGIT2_EN: process two bits of b per CALC cycle (16-cycle CALC).
// Bus bit 1 is the x^31 coefficient, bit 32 is x^0.
module gf32_serial_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:32] a,
  input  logic [1:32] b,
  input  logic [1:32] poly,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:32] c,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [1:32] r_a;
  logic [1:32] r_b;
  logic [1:32] r_poly;
  logic [1:32] r_acc;
  logic [4:0]  r_cnt;
  logic [1:32] r_c;

  logic [1:32] w_acc_nxt;
  logic [1:32] w_b_nxt;
  logic        w_last;
  logic        w_accept;

  // One MSB-first step: multiply acc by x, fold the x^32 overflow back via poly, add a if the b bit is set
  function automatic logic [1:32] gf_step(input logic [1:32] acc_v, input logic [1:32] a_v,
                                          input logic [1:32] p_v, input logic bit_v);
    logic [1:32] t;
    t = {acc_v[2:32], 1'b0} ^ (acc_v[1] ? p_v : 32'd0);
    if (bit_v) t = t ^ a_v;
    return t;
  endfunction

  // r_b is shifted toward bit 1 each cycle, so the bit(s) under scan always sit at the top
`ifdef GF32_DIGIT2_EN
  localparam logic [4:0] LAST_CNT = 5'd15;
  assign w_acc_nxt = gf_step(gf_step(r_acc, r_a, r_poly, r_b[1]), r_a, r_poly, r_b[2]);
  assign w_b_nxt   = {r_b[3:32], 2'b00};
`else
  localparam logic [4:0] LAST_CNT = 5'd31;
  assign w_acc_nxt = gf_step(r_acc, r_a, r_poly, r_b[1]);
  assign w_b_nxt   = {r_b[2:32], 1'b0};
`endif

  assign w_last   = (r_cnt == LAST_CNT);
  assign w_accept = in_valid && (r_state == S_IDLE);
  assign c        = r_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_CALC;
      S_CALC:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs; in_ready is also held low while reset is asserted
  always_comb begin
    in_ready  = (r_state == S_IDLE) && rst;
    out_valid = (r_state == S_DONE);
    busy      = (r_state == S_CALC);
  end

  // Operand capture, accumulator steps, and result register (c only changes on completion)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_poly <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_c    <= '0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_poly <= poly;
      r_acc  <= '0;
      r_cnt  <= '0;
    end else if (r_state == S_CALC) begin
      r_acc  <= w_acc_nxt;
      r_b    <= w_b_nxt;
      r_cnt  <= r_cnt + 5'd1;
      if (w_last) r_c <= w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_gf32_serial_mult.sv
// tb/tb_gf32_serial_mult.sv - scoreboard bench for gf32_serial_mult against a polynomial-arithmetic model
module tb_gf32_serial_mult;

`ifdef GF32_DIGIT2_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif
  localparam int THRU = LAT + 2;
  localparam logic [31:0] P0 = 32'h00400007;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] poly = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] c;

  gf32_serial_mult dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .poly(poly), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int t_acc = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, expv);
    end
  endtask

  // Reference: full carry-less product, then reduce by x^32 + poly from the top degree down
  function automatic logic [31:0] gf_ref(input logic [31:0] x, input logic [31:0] y, input logic [31:0] p);
    logic [63:0] prod;
    logic [63:0] pf;
    prod = '0;
    pf = {31'b0, 1'b1, p};
    for (int i = 0; i < 32; i++)
      if (y[i]) prod = prod ^ ({32'b0, x} << i);
    for (int i = 63; i >= 32; i--)
      if (prod[i]) prod = prod ^ (pf << (i - 32));
    return prod[31:0];
  endfunction

  // Monitor: latency on each out_valid rise, product compare on each output handshake
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && !prev_ov) check("latency", 32'(cyc - t_acc), 32'(LAT));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%08h with empty scoreboard", c);
        end else begin
          check("product", c, exp_q.pop_front());
        end
      end
    end
    prev_ov <= out_valid;
  end

  // Present operands after a rising edge, hold until accepted, record the accept edge
  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tp,
                      input logic [31:0] ex);
    int k;
    @(posedge clk); #1;
    a = ta; b = tb; poly = tp; in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
      t_acc = cyc;
      exp_q.push_back(ex);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && in_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!(exp_q.size() == 0 && in_ready)) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%0b required 0/1", exp_q.size(), in_ready);
    end
  endtask

  task automatic one(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tp,
                     input logic [31:0] ex);
    send(ta, tb, tp, ex);
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rp, ex;
    int acc_t[4];
    int k;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_c", c, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Identity, with busy/in_ready observed during CALC
    send(32'h00000001, 32'h12345678, P0, 32'h12345678);
    in_valid = 1'b0;
    @(negedge clk);
    check("calc_busy", 32'(busy), 32'd1);
    check("calc_in_ready", 32'(in_ready), 32'd0);
    drain();

    // Reduction, commutativity, zero operand, poly = 0
    one(32'h80000000, 32'h00000002, P0, 32'h00400007);
    one(32'h00000002, 32'h80000000, P0, 32'h00400007);
    one(32'h00000000, 32'hFFFFFFFF, P0, 32'h00000000);
    ra = $urandom; rb = $urandom;
    one(ra, rb, 32'h0, gf_ref(ra, rb, 32'h0));

    // Backpressure with in_valid toggling and new operands on the inputs
    out_ready = 1'b0;
    ra = $urandom; rb = $urandom; rp = $urandom;
    ex = gf_ref(ra, rb, rp);
    send(ra, rb, rp, ex);
    in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("bp_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; poly = $urandom;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_c_stable", c, ex);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_c_kept", c, ex);
    drain();

    // Reset during CALC step 15
    ra = $urandom | 32'h1; rb = $urandom | 32'h1; rp = $urandom;
    send(ra, rb, rp, gf_ref(ra, rb, rp));
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_c", c, 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    one(32'h00000003, 32'h00000003, P0, 32'h00000005);

    // Back-to-back with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rp = $urandom;
      send(ra, rb, rp, gf_ref(ra, rb, rp));
      acc_t[i] = t_acc;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++)
      check("b2b_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'(THRU));
    drain();

    // Additional random operands
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rp = $urandom;
      one(ra, rb, rp, gf_ref(ra, rb, rp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
